// File: rtl/f2i_accum.sv
// Frame accumulator behind a float-to-int converter: sums FRAME_LEN beats with
// 32-bit saturation, ORs the converter flags over the frame, and holds the result until handshake.
module f2i_accum #(
   parameter int FRAME_LEN = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sclr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_d,
   input  logic        in_p_lost,
   input  logic        in_denorm,
   input  logic        in_invalid,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic [7:0]  out_count,
   output logic        out_p_lost,
   output logic        out_denorm,
   output logic        out_invalid,
   output logic        out_sat
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN);

   state_t      state_q, state_d;
   logic [7:0]  beat_q, beat_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] sum_q, sum_d;
   logic        p_lost_q, p_lost_d;
   logic        denorm_q, denorm_d;
   logic        invalid_q, invalid_d;
   logic        sat_q, sat_d;
   logic [32:0] add_ext;

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      cnt_d     = cnt_q;
      sum_d     = sum_q;
      p_lost_d  = p_lost_q;
      denorm_d  = denorm_q;
      invalid_d = invalid_q;
      sat_d     = sat_q;
      add_ext   = {sum_q[31], sum_q} + {in_d[31], in_d};

      if (sclr || (state_q == HOLD && out_ready)) begin
         state_d   = ACCUM;
         beat_d    = 8'd0;
         cnt_d     = 8'd0;
         sum_d     = 32'd0;
         p_lost_d  = 1'b0;
         denorm_d  = 1'b0;
         invalid_d = 1'b0;
         sat_d     = 1'b0;
      end else if (state_q == ACCUM && in_valid) begin
         beat_d    = beat_q + 8'd1;
         p_lost_d  = p_lost_q | in_p_lost;
         denorm_d  = denorm_q | in_denorm;
         invalid_d = invalid_q | in_invalid;
         if (!in_invalid) begin
            cnt_d = cnt_q + 8'd1;
            // Sign bits disagree at 33 bits: result left the 32-bit range.
            if (add_ext[32] != add_ext[31]) begin
               sum_d = add_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
               sat_d = 1'b1;
            end else begin
               sum_d = add_ext[31:0];
            end
         end
         if (beat_d == LAST_BEAT) state_d = HOLD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ACCUM;
         beat_q    <= 8'd0;
         cnt_q     <= 8'd0;
         sum_q     <= 32'd0;
         p_lost_q  <= 1'b0;
         denorm_q  <= 1'b0;
         invalid_q <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         cnt_q     <= cnt_d;
         sum_q     <= sum_d;
         p_lost_q  <= p_lost_d;
         denorm_q  <= denorm_d;
         invalid_q <= invalid_d;
         sat_q     <= sat_d;
      end
   end

   assign in_ready    = (state_q == ACCUM);
   assign out_valid   = (state_q == HOLD);
   assign out_sum     = sum_q;
   assign out_count   = cnt_q;
   assign out_p_lost  = p_lost_q;
   assign out_denorm  = denorm_q;
   assign out_invalid = invalid_q;
   assign out_sat     = sat_q;

endmodule

// File: tb/tb_f2i_accum.sv
// Directed bench for f2i_accum (FRAME_LEN=4): expected frame results are queued
// at issue time and checked by a monitor when out_valid rises.
module tb_f2i_accum;

   typedef struct packed {
      logic [31:0] sum;
      logic [7:0]  count;
      logic        p_lost;
      logic        denorm;
      logic        invalid;
      logic        sat;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclr = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_d = '0;
   logic        in_p_lost = 1'b0;
   logic        in_denorm = 1'b0;
   logic        in_invalid = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_sum;
   logic [7:0]  out_count;
   logic        out_p_lost, out_denorm, out_invalid, out_sat;

   int   n_tests = 0;
   int   n_fail  = 0;
   res_t exp_q[$];
   logic done = 1'b0;

   f2i_accum #(.FRAME_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .sclr(sclr),
      .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
      .in_p_lost(in_p_lost), .in_denorm(in_denorm), .in_invalid(in_invalid),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_p_lost(out_p_lost), .out_denorm(out_denorm),
      .out_invalid(out_invalid), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   function automatic res_t cur();
      return '{out_sum, out_count, out_p_lost, out_denorm, out_invalid, out_sat};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   task automatic expect_frame(input logic [31:0] s, input logic [7:0] c,
                               input logic pl, input logic dn, input logic iv, input logic st);
      exp_q.push_back('{s, c, pl, dn, iv, st});
   endtask

   task automatic beat(input int d, input logic pl = 1'b0, input logic dn = 1'b0,
                       input logic iv = 1'b0);
      in_valid = 1'b1; in_d = d; in_p_lost = pl; in_denorm = dn; in_invalid = iv;
      @(posedge clk); #1;
      in_valid = 1'b0; in_p_lost = 1'b0; in_denorm = 1'b0; in_invalid = 1'b0;
   endtask

   task automatic ack();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("ack_in_ready", 64'(in_ready), 64'd1);
      check("ack_sum_clr", 64'(out_sum), 64'd0);
      check("ack_cnt_clr", 64'(out_count), 64'd0);
   endtask

   // Monitor: one comparison per frame, on the cycle out_valid first appears.
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (out_valid && !prev_valid) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_frame: actual sum %0h required no frame", out_sum);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            if (cur() !== e) begin
               n_fail++;
               $display("FAIL frame: actual %0h required %0h", cur(), e);
            end
         end
      end
      prev_valid <= out_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t held;
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(cur()), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Plain sum, then hold with in_valid asserted and no out_ready
      expect_frame(32'd114, 8'd4, 0, 0, 0, 0);
      beat(10); beat(-3); beat(100);
      check("pre_last_valid", 64'(out_valid), 64'd0);
      beat(7);
      check("last_beat_valid", 64'(out_valid), 64'd1);
      held = cur();
      in_valid = 1'b1; in_d = 32'd55;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("hold_in_ready", 64'(in_ready), 64'd0);
         check("hold_stable", 64'(cur()), 64'(held));
      end
      in_valid = 1'b0;
      ack();

      // Positive saturation; accumulation resumes from the clamp
      expect_frame(32'h7FFF_FFFE, 8'd4, 0, 0, 0, 1);
      beat(32'h7FFF_FFF0); beat(32'h20); beat(-1); beat(0);
      ack();

      // Invalid beat ignored for sum/count, flags sticky
      expect_frame(32'd15, 8'd3, 1, 0, 1, 0);
      beat(5); beat(32'h8000_0000, 0, 0, 1); beat(5, 1); beat(5);
      ack();

      // Negative saturation with denorm flag
      expect_frame(32'h8000_0003, 8'd4, 0, 1, 0, 1);
      beat(32'h8000_0001); beat(-5, 0, 1); beat(3); beat(0);
      ack();

      // Async reset between edges mid-frame
      beat(40); beat(50);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_sum", 64'(out_sum), 64'd0);
      check("async_rst_cnt", 64'(out_count), 64'd0);
      check("async_rst_ready", 64'(in_ready), 64'd1);
      #1 rst_n = 1'b1;
      expect_frame(32'd10, 8'd4, 0, 0, 0, 0);
      @(posedge clk); #1;
      beat(1); beat(2); beat(3); beat(4);
      ack();

      // sclr mid-frame with in_valid: beat dropped, frame restarts
      beat(1); beat(1);
      sclr = 1'b1; in_valid = 1'b1; in_d = 32'd100;
      @(posedge clk); #1;
      sclr = 1'b0; in_valid = 1'b0;
      check("sclr_mid_sum", 64'(out_sum), 64'd0);
      check("sclr_mid_cnt", 64'(out_count), 64'd0);
      expect_frame(32'd4, 8'd4, 0, 0, 0, 0);
      beat(1); beat(1); beat(1);
      check("sclr_mid_partial", 64'(out_valid), 64'd0);
      beat(1);

      // sclr together with out_ready while in HOLD
      sclr = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_d = 32'd50;
      @(posedge clk); #1;
      sclr = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      check("sclr_hold_ready", 64'(in_ready), 64'd1);
      check("sclr_hold_sum", 64'(out_sum), 64'd0);
      expect_frame(32'd4, 8'd4, 0, 0, 0, 0);
      beat(1); beat(1); beat(1); beat(1);
      ack();

      @(negedge clk); @(negedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/f2i_accum.md
F2I_ACCUM -- requirements
Module: f2i_accum

Interface
REQ-001 Parameter FRAME_LEN, default 8, number of accepted input beats per frame; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sclr  input  1  synchronous clear; abandons the current frame.
REQ-005 in_valid  input  1  input beat valid.
REQ-006 in_ready  output  1  block can accept an input beat.
REQ-007 in_d  input  32  signed integer produced by the float-to-int converter stage.
REQ-008 in_p_lost  input  1  converter precision-lost flag for this beat.
REQ-009 in_denorm  input  1  converter denormalized-input flag for this beat.
REQ-010 in_invalid  input  1  converter invalid flag for this beat (inf, NaN, out of range).
REQ-011 out_valid  output  1  frame result valid.
REQ-012 out_ready  input  1  downstream accepts the frame result.
REQ-013 out_sum  output  32  signed saturated sum of the frame's non-invalid beats.
REQ-014 out_count  output  8  number of non-invalid beats summed into the frame.
REQ-015 out_p_lost, out_denorm, out_invalid  output  1 each  sticky OR of the corresponding input flag over the frame.
REQ-016 out_sat  output  1  sticky; set if any addition in the frame saturated.

Function
REQ-017 Two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 Input beat accepted on a rising edge where in_valid=1 and in_ready=1; all other edges leave the accumulator state unchanged.
REQ-019 On acceptance, an 8-bit beat counter increments by 1, regardless of flags.
REQ-020 On acceptance with in_invalid=0: out_sum <= sat32(out_sum + in_d), with the addition done at 33 bits signed; out_count increments by 1.
REQ-021 sat32 clamps to 0x7FFFFFFF on positive overflow and to 0x80000000 on negative overflow, and sets out_sat; accumulation continues from the clamped value.
REQ-022 On acceptance with in_invalid=1: in_d is ignored; out_sum and out_count are unchanged.
REQ-023 On every acceptance: out_p_lost, out_denorm and out_invalid each OR in the corresponding input flag.
REQ-024 The edge accepting beat number FRAME_LEN moves ACCUM->HOLD and updates the outputs with that beat; out_valid=1 from that edge on. Latency from last beat to result is 0 cycles after the accepting edge.
REQ-025 In HOLD, all out_* result signals are held stable until handshake; in_valid is ignored.
REQ-026 On an edge in HOLD with out_ready=1, the block returns to ACCUM and clears the beat counter, out_sum, out_count and all sticky flags to 0; in_ready=1 in the next cycle; no bubble beyond that.
REQ-027 out_valid does not depend combinationally on out_ready; in_ready does not depend combinationally on in_valid.
REQ-028 sclr=1 at an edge clears the beat counter, out_sum, out_count and all sticky flags and forces ACCUM; it takes priority over input acceptance and output handshake on the same edge.
REQ-029 With FRAME_LEN=1, every accepted beat moves the block to HOLD.

Reset
REQ-030 rst_n=0 immediately, without waiting for clk, forces ACCUM, the beat counter to 0, out_sum=0, out_count=0, all sticky flags=0, out_valid=0 and in_ready=1, including mid-frame and in HOLD.
REQ-031 After rst_n deasserts, the first accepted beat is beat 1 of a new frame.

Verification (FRAME_LEN=4)
REQ-032 Beats 10, -3, 100, 7, all flags clear -> out_valid=1 after the 4th edge, out_sum=114, out_count=4, all flags 0.
REQ-033 Beats 0x7FFFFFF0, 0x20, -1, 0 -> out_sum=0x7FFFFFFE, out_sat=1, out_count=4.
REQ-034 Beats 5, (0x80000000 with in_invalid=1), (5 with in_p_lost=1), 5 -> out_sum=15, out_count=3, out_invalid=1, out_p_lost=1, out_denorm=0.
REQ-035 Frame complete with out_ready=0 for 3 cycles while in_valid=1 -> outputs stable, in_ready=0, no beats counted; out_ready=1 -> next cycle in_ready=1, out_sum=0, out_count=0.
REQ-036 Two beats accepted, then rst_n pulsed low between edges -> outputs 0 asynchronously; next frame of 1, 2, 3, 4 -> out_sum=10.
REQ-037 sclr=1 on the same edge as out_ready=1, or mid-frame with in_valid=1 -> state cleared, that beat not counted; next 4 beats of 1 -> out_sum=4.
